keccak_pi_step: RTL and testbench

- Registered Keccak-f[1600] pi step (FIPS 202 §3.2.3): lane permutation A'[x][y] = A[(x+3y) mod 5][x].
- Sits in the Keccak round datapath between rho and chi.
- One pipeline register stage with valid/ready handshake.
- Permutation is pure wiring; no bit within a lane is altered.

---
 rtl/keccak_pkg.sv | 9 +
 rtl/keccak_pi_step_if.sv | 21 ++
 rtl/keccak_pi_step.sv | 51 +++++
 tb/tb_keccak_pi_step.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Keccak-f[1600] state geometry and shared state type.
package keccak_pkg;
  localparam int unsigned LANE_SIZE = 64;
  localparam int unsigned ROW_SIZE  = 5;
  localparam int unsigned COL_SIZE  = 5;

  // State indexed [x][y][z], x outermost.
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
endpackage

// File: rtl/keccak_pi_step_if.sv
// Valid/ready state bus around one Keccak round step.
interface keccak_pi_step_if;
  import keccak_pkg::*;

  logic   valid_i;
  logic   ready_o;
  state_t state_array_i;
  logic   valid_o;
  logic   ready_i;
  state_t state_array_o;

  modport master (
    output valid_i, state_array_i, ready_i,
    input  ready_o, valid_o, state_array_o
  );

  modport slave (
    input  valid_i, state_array_i, ready_i,
    output ready_o, valid_o, state_array_o
  );
endinterface

// File: rtl/keccak_pi_step.sv
// Registered Keccak pi lane permutation with a single valid/ready pipeline stage.
module keccak_pi_step
  import keccak_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  keccak_pi_step_if.slave bus
);

  state_t perm;
  state_t state_d, state_q;
  logic   valid_d, valid_q;
  logic   ready_c;
  logic   accept_c;

  // A'[x][y] = A[(x+3y) mod 5][x]; pure wiring.
  for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_row
    for (genvar gy = 0; gy < COL_SIZE; gy++) begin : g_col
      assign perm[gx][gy] = bus.state_array_i[(gx + 3 * gy) % ROW_SIZE][gx];
    end
  end

  assign ready_c  = !valid_q || bus.ready_i;
  assign accept_c = bus.valid_i && ready_c;

  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    if (accept_c) begin
      valid_d = 1'b1;
      state_d = perm;
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      state_q <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign bus.ready_o       = ready_c;
  assign bus.valid_o       = valid_q;
  assign bus.state_array_o = state_q;

endmodule

// File: tb/tb_keccak_pi_step.sv
// Bench for keccak_pi_step: vector table, backpressure, streaming and async reset.
module tb_keccak_pi_step;
  import keccak_pkg::*;

  typedef struct {
    string  name;
    state_t in;
    state_t exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  keccak_pi_step_if bus ();

  keccak_pi_step dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: forward mapping, lane (x,y) moves to (y, (2x+3y) mod 5), on a flat lane list.
  function automatic state_t ref_pi(input state_t s);
    logic [LANE_SIZE-1:0] src [25];
    logic [LANE_SIZE-1:0] dst [25];
    state_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        src[5*x + y] = s[x][y];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        dst[5*y + ((2*x + 3*y) % 5)] = src[5*x + y];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = dst[5*x + y];
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_lane(input string name, input logic [LANE_SIZE-1:0] act,
                          input logic [LANE_SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reports the first differing lane only, keeping lines short.
  task automatic chk_state(input string name, input state_t act, input state_t exp);
    bool_loop : begin
      checks++;
      if (act !== exp) begin
        errors++;
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++)
            if (act[x][y] !== exp[x][y]) begin
              $display("FAIL %s: lane[%0d][%0d] got %h expected %h",
                       name, x, y, act[x][y], exp[x][y]);
              disable bool_loop;
            end
      end
    end
  endtask

  vec_t   vecs [4];
  state_t held;
  state_t s;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.state_array_i = '0;

    // Vector table.
    vecs[0].name = "single_bit";
    vecs[0].in = '0;  vecs[0].in[1][0] = 64'h1;
    vecs[0].exp = '0; vecs[0].exp[0][2] = 64'h1;
    vecs[1].name = "all_ones";
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        vecs[1].in[x][y]  = 64'h1;
        vecs[1].exp[x][y] = 64'h1;
      end
    vecs[2].name = "sequential";
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        vecs[2].in[x][y] = 64'(5*x + y);
    vecs[2].exp = ref_pi(vecs[2].in);
    vecs[3].name = "random";
    vecs[3].in  = rand_state();
    vecs[3].exp = ref_pi(vecs[3].in);

    #12;
    chk_bit("reset_valid_o", bus.valid_o, 1'b0);
    chk_state("reset_state_o", bus.state_array_o, '0);
    chk_bit("reset_ready_o", bus.ready_o, 1'b1);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      bus.state_array_i = vecs[i].in;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      chk_bit({vecs[i].name, "_valid"}, bus.valid_o, 1'b1);
      chk_state({vecs[i].name, "_state"}, bus.state_array_o, vecs[i].exp);
      bus.valid_i = 1'b0;
      bus.state_array_i = rand_state();
      @(posedge clk); #1;
      chk_bit({vecs[i].name, "_drain_valid"}, bus.valid_o, 1'b0);
      chk_state({vecs[i].name, "_drain_hold"}, bus.state_array_o, vecs[i].exp);
    end

    // Sequential-pattern spot values: 5*((x+3y) mod 5)+x.
    bus.state_array_i = vecs[2].in;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk_lane("seq_out00", bus.state_array_o[0][0], 64'd0);
    chk_lane("seq_out11", bus.state_array_o[1][1], 64'd21);
    chk_lane("seq_out23", bus.state_array_o[2][3], 64'd7);
    chk_lane("seq_out44", bus.state_array_o[4][4], 64'd9);
    chk_lane("seq_out01", bus.state_array_o[0][1], 64'd15);
    @(posedge clk); #1;

    // Backpressure: stall 3 cycles with changing input, then release.
    s = rand_state();
    held = ref_pi(s);
    bus.state_array_i = s;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.valid_i = c[0] ? 1'b0 : 1'b1;
      bus.state_array_i = rand_state();
      #1;
      chk_bit("stall_ready_o", bus.ready_o, 1'b0);
      @(posedge clk); #1;
      chk_bit("stall_valid_o", bus.valid_o, 1'b1);
      chk_state("stall_hold", bus.state_array_o, held);
    end
    s = rand_state();
    bus.state_array_i = s;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    chk_bit("release_ready_o", bus.ready_o, 1'b1);
    @(posedge clk); #1;
    chk_bit("release_valid_o", bus.valid_o, 1'b1);
    chk_state("release_state", bus.state_array_o, ref_pi(s));

    // Streaming: back-to-back random states at full throughput.
    for (int i = 0; i < 25; i++) begin
      s = rand_state();
      bus.state_array_i = s;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      chk_bit("stream_valid_o", bus.valid_o, 1'b1);
      chk_state("stream_state", bus.state_array_o, ref_pi(s));
    end

    // Asynchronous reset between edges while a state is in flight.
    bus.state_array_i = rand_state();
    #2 rst_n = 1'b0;
    #1;
    chk_bit("async_rst_valid_o", bus.valid_o, 1'b0);
    chk_state("async_rst_state", bus.state_array_o, '0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_bit("post_rst_valid_o", bus.valid_o, 1'b0);
    chk_state("post_rst_state", bus.state_array_o, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
